// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: N_REQ producers share one queue write port through a
// one-entry output register, with optional short-burst grant locking and flush.
module fifo_wr_arbiter #(
  parameter int DATA_BITS = 8,
  parameter int ID_BITS   = 2,
  parameter int BURST_MAX = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [(2**ID_BITS)-1:0]      req_valid,
  input  logic [(2**ID_BITS)-1:0]      req_lock,
  input  logic [(2**ID_BITS)*DATA_BITS-1:0] req_data,
  output logic [(2**ID_BITS)-1:0]      req_ready,
  output logic                         q_wr_en,
  output logic [ID_BITS+DATA_BITS-1:0] q_wr_data,
  input  logic                         q_full,
  output logic                         busy,
  output logic [ID_BITS-1:0]           locked_id
);

  localparam int N_REQ = 2**ID_BITS;
  localparam int CNT_W = $clog2(BURST_MAX + 1);

  // Handshake: a beat from requester i transfers on a rising clk edge where
  // req_valid[i] && req_ready[i]; req_ready never depends on req_valid of others
  // beyond arbitration and is only raised when the output register has space.
  typedef enum logic [0:0] {IDLE, LOCKED} state_t;

  state_t               state;
  logic [ID_BITS-1:0]   owner;
  logic [CNT_W-1:0]     beat_cnt;
  logic [ID_BITS-1:0]   rr_ptr;
  logic                 ob_valid;
  logic [ID_BITS-1:0]   ob_id;
  logic [DATA_BITS-1:0] ob_data;

  logic                 drain;
  logic                 space;
  logic                 any_valid;
  logic [ID_BITS-1:0]   win_id;
  logic [ID_BITS-1:0]   scan_id;
  logic [ID_BITS-1:0]   acc_id;
  logic [DATA_BITS-1:0] acc_data;
  logic                 accept;

  assign drain     = ob_valid && !q_full;
  assign space     = !ob_valid || drain;
  assign q_wr_en   = drain && !flush;
  assign q_wr_data = {ob_id, ob_data};
  assign busy      = ob_valid || (state == LOCKED);
  assign locked_id = (state == LOCKED) ? owner : '0;

  // First valid requester scanning upward from rr_ptr with natural wrap.
  always_comb begin
    win_id    = rr_ptr;
    any_valid = 1'b0;
    scan_id   = rr_ptr;
    for (int k = 0; k < N_REQ; k++) begin
      scan_id = rr_ptr + ID_BITS'(k);
      if (!any_valid && req_valid[scan_id]) begin
        any_valid = 1'b1;
        win_id    = scan_id;
      end
    end
  end

  always_comb begin
    acc_id    = (state == LOCKED) ? owner : win_id;
    req_ready = '0;
    if (!flush && space) begin
      if (state == IDLE) begin
        if (any_valid) req_ready[win_id] = 1'b1;
      end else if (req_valid[owner]) begin
        req_ready[owner] = 1'b1;
      end
    end
    accept   = |req_ready;
    acc_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (acc_id == ID_BITS'(i)) acc_data = req_data[i*DATA_BITS +: DATA_BITS];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= '0;
      beat_cnt <= '0;
      rr_ptr   <= '0;
      ob_valid <= 1'b0;
      ob_id    <= '0;
      ob_data  <= '0;
    end else if (flush) begin
      ob_valid <= 1'b0;
      state    <= IDLE;
      beat_cnt <= '0;
    end else begin
      if (drain) ob_valid <= 1'b0;
      if (accept) begin
        ob_valid <= 1'b1;
        ob_id    <= acc_id;
        ob_data  <= acc_data;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            rr_ptr <= win_id + ID_BITS'(1);
            if (req_lock[win_id] && (BURST_MAX > 1)) begin
              state    <= LOCKED;
              owner    <= win_id;
              beat_cnt <= CNT_W'(1);
            end
          end
        end
        LOCKED: begin
          // An owner that goes quiet gives up the lock without a beat.
          if (!req_valid[owner]) begin
            state    <= IDLE;
            beat_cnt <= '0;
          end else if (accept) begin
            if (!req_lock[owner] || (beat_cnt + CNT_W'(1) == CNT_W'(BURST_MAX))) begin
              state    <= IDLE;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a vector table of per-cycle inputs and
// expected outputs, followed by a scoreboarded round-robin rotation sequence.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [3:0]  req_valid;
  logic [3:0]  req_lock;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        q_wr_en;
  logic [9:0]  q_wr_data;
  logic        q_full;
  logic        busy;
  logic [1:0]  locked_id;

  fifo_wr_arbiter #(.DATA_BITS(8), .ID_BITS(2), .BURST_MAX(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .req_valid (req_valid),
    .req_lock  (req_lock),
    .req_data  (req_data),
    .req_ready (req_ready),
    .q_wr_en   (q_wr_en),
    .q_wr_data (q_wr_data),
    .q_full    (q_full),
    .busy      (busy),
    .locked_id (locked_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        chk;
    logic        rst;
    logic        fl;
    logic        full;
    logic [3:0]  valid;
    logic [3:0]  lock;
    logic [31:0] data;
    logic [3:0]  e_ready;
    logic        e_wen;
    logic [9:0]  e_wdata;
    logic        e_busy;
    logic [1:0]  e_lid;
  } vec_t;

  vec_t        vecs[$];
  logic [9:0]  exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  localparam logic [31:0] D0  = 32'h4433_2211;
  localparam logic [31:0] DA  = 32'h00A5_0000;
  localparam logic [31:0] D55 = 32'h4433_2255;

  function automatic void add(input logic rst, input logic fl, input logic full,
                              input logic [3:0] valid, input logic [3:0] lock,
                              input logic [31:0] data, input logic [3:0] e_ready,
                              input logic e_wen, input logic [9:0] e_wdata,
                              input logic e_busy, input logic [1:0] e_lid);
    vec_t v;
    v.chk = !rst; v.rst = rst; v.fl = fl; v.full = full;
    v.valid = valid; v.lock = lock; v.data = data;
    v.e_ready = e_ready; v.e_wen = e_wen; v.e_wdata = e_wdata;
    v.e_busy = e_busy; v.e_lid = e_lid;
    vecs.push_back(v);
  endfunction

  task automatic drive(input logic rst, input logic fl, input logic full,
                       input logic [3:0] valid, input logic [3:0] lock,
                       input logic [31:0] data);
    reset = rst; flush = fl; q_full = full;
    req_valid = valid; req_lock = lock; req_data = data;
  endtask

  task automatic check_vec(input int idx, input vec_t v);
    logic [17:0] got, exp;
    got = {req_ready, q_wr_en, q_wr_data, busy, locked_id};
    exp = {v.e_ready, v.e_wen, v.e_wdata, v.e_busy, v.e_lid};
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL vec%0d: got ready=%b wen=%b wdata=%h busy=%b lid=%0d, expected ready=%b wen=%b wdata=%h busy=%b lid=%0d",
               idx, req_ready, q_wr_en, q_wr_data, busy, locked_id,
               v.e_ready, v.e_wen, v.e_wdata, v.e_busy, v.e_lid);
    end
  endtask

  initial begin
    // Post-reset quiet period.
    for (int i = 0; i < 10; i++) add(0,0,0, 4'h0,4'h0, 32'h0, 4'h0,0,10'h000,0,0);
    // Single offer from ID 2, written one cycle later.
    add(0,0,0, 4'b0100,4'h0, DA, 4'b0100,0,10'h000,0,0);
    add(0,0,0, 4'h0,4'h0, DA,    4'h0,1,10'h2A5,1,0);
    add(0,0,0, 4'h0,4'h0, DA,    4'h0,0,10'h2A5,0,0);
    // All valid, no locks: rotation from rr_ptr=3 with wrap.
    add(0,0,0, 4'hF,4'h0, D0, 4'b1000,0,10'h2A5,0,0);
    add(0,0,0, 4'hF,4'h0, D0, 4'b0001,1,10'h344,1,0);
    add(0,0,0, 4'hF,4'h0, D0, 4'b0010,1,10'h011,1,0);
    add(0,0,0, 4'hF,4'h0, D0, 4'b0100,1,10'h122,1,0);
    add(0,0,0, 4'hF,4'h0, D0, 4'b1000,1,10'h233,1,0);
    add(0,0,0, 4'hF,4'h0, D0, 4'b0001,1,10'h344,1,0);
    add(0,0,0, 4'h0,4'h0, D0, 4'h0,1,10'h011,1,0);
    // ID 1 locks: four beats, then ID 2.
    add(0,0,0, 4'hF,4'b0010, D0, 4'b0010,0,10'h011,0,0);
    for (int i = 0; i < 3; i++) add(0,0,0, 4'hF,4'b0010, D0, 4'b0010,1,10'h122,1,1);
    add(0,0,0, 4'hF,4'b0010, D0, 4'b0100,1,10'h122,1,0);
    add(0,0,0, 4'h0,4'h0,    D0, 4'h0,1,10'h233,1,0);
    // Stall: held {0,11} under q_full, released with same-cycle accept.
    add(0,0,0, 4'b0001,4'h0, D0, 4'b0001,0,10'h233,0,0);
    for (int i = 0; i < 5; i++) add(0,0,1, 4'b0001,4'h0, D55, 4'h0,0,10'h011,1,0);
    add(0,0,0, 4'b0001,4'h0, D55, 4'b0001,1,10'h011,1,0);
    add(0,0,0, 4'h0,4'h0,    D55, 4'h0,1,10'h055,1,0);
    // Flush with held entry, active lock and q_full together.
    add(0,0,0, 4'b0010,4'b0010, D0, 4'b0010,0,10'h055,0,0);
    add(0,1,1, 4'b0010,4'b0010, D0, 4'h0,0,10'h122,1,1);
    add(0,0,0, 4'h0,4'h0,       D0, 4'h0,0,10'h122,0,0);
    add(0,0,0, 4'hF,4'h0,       D0, 4'b0100,0,10'h122,0,0);
    add(0,0,0, 4'h0,4'h0,       D0, 4'h0,1,10'h233,1,0);
    // Owner 3 drops valid after two beats.
    add(0,0,0, 4'hF,4'b1000,    D0, 4'b1000,0,10'h233,0,0);
    add(0,0,0, 4'hF,4'b1000,    D0, 4'b1000,1,10'h344,1,3);
    add(0,0,0, 4'b0111,4'b1000, D0, 4'h0,1,10'h344,1,3);
    add(0,0,0, 4'b0111,4'h0,    D0, 4'b0001,0,10'h344,0,0);
    add(0,0,0, 4'h0,4'h0,       D0, 4'h0,1,10'h011,1,0);
    // Reset in the middle of a locked burst.
    add(0,0,0, 4'b0010,4'b0010, D0, 4'b0010,0,10'h011,0,0);
    add(1,0,0, 4'b0010,4'b0010, D0, 4'h0,0,10'h000,0,0);
    add(0,0,0, 4'h0,4'h0,       D0, 4'h0,0,10'h000,0,0);

    drive(1,0,0, 4'h0,4'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    drive(0,0,0, 4'h0,4'h0, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].fl, vecs[i].full, vecs[i].valid, vecs[i].lock, vecs[i].data);
      #1;
      if (vecs[i].chk) check_vec(i, vecs[i]);
    end

    // Rotation from a fresh rr_ptr: every write is matched against exp_q.
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(10'h011); exp_q.push_back(10'h122);
      exp_q.push_back(10'h233); exp_q.push_back(10'h344);
    end
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      drive(0,0,0, (cyc < 8) ? 4'hF : 4'h0, 4'h0, D0);
      #1;
      if (q_wr_en) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rr_extra_write: got wdata=%h, expected no write", q_wr_data);
        end else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          if (q_wr_data !== e) begin
            n_fail++;
            $display("FAIL rr_write: got wdata=%h, expected %h", q_wr_data, e);
          end
        end
      end
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rr_drain_timeout: got %0d writes missing, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
